// File: rtl/sobel_stream_core.sv
// sobel_stream_core -- streaming 3x3 Sobel edge detector.
//
// Raster-order pixels enter on DataIn. Two IMG_W-deep line buffers and a
// 3x3 window produce one gradient result per pixel once the window has
// filled. After the last real pixel the block injects IMG_W+1 zero pixels
// (isPadding=1) so that the bottom row is also produced. Frame borders
// read as zero by masking window taps on the result coordinates.
//
// Ports:
//   Clk, Reset           clock, synchronous active-high reset
//   Enable               advance qualifier for all counters and stages
//   DataIn               input pixel (ignored while isPadding=1)
//   T                    unsigned edge threshold, captured with each trigger
//   Out_Row, Out_Column  coordinates of the current result
//   Mag                  saturated |Gx|+|Gy|
//   Dop                  edge flag: unsaturated |Gx|+|Gy| > T
//   isReady              result valid this cycle
//   isEnd                pulse with the last result of a frame
//   isPadding            block is injecting zero pixels
//
// Build option: define SOBEL_MAG_OUT_EN to drive Mag with the saturated
// magnitude; when undefined Mag is tied to zero and Dop is unaffected.
module sobel_stream_core #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Enable,
  input  logic [DATA_W-1:0]        DataIn,
  input  logic [DATA_W-1:0]        T,
  output logic [$clog2(IMG_H)-1:0] Out_Row,
  output logic [$clog2(IMG_W)-1:0] Out_Column,
  output logic [DATA_W-1:0]        Mag,
  output logic                     Dop,
  output logic                     isReady,
  output logic                     isEnd,
  output logic                     isPadding
);

  localparam int RW   = $clog2(IMG_H);
  localparam int CW   = $clog2(IMG_W);
  localparam int GW   = DATA_W + 3;
  localparam int NPIX = IMG_W * IMG_H;
  localparam int KW   = $clog2(NPIX + IMG_W + 1);

  localparam logic [KW-1:0] K_FILL_END  = KW'(IMG_W);
  localparam logic [KW-1:0] K_RUN_END   = KW'(NPIX - 1);
  localparam logic [KW-1:0] K_FLUSH_END = KW'(NPIX + IMG_W);
  localparam logic [RW-1:0] ROW_LAST    = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST    = CW'(IMG_W - 1);

  typedef enum logic [1:0] {S_FILL, S_RUN, S_FLUSH} state_t;

  function automatic logic signed [GW-1:0] ext1(input logic [DATA_W-1:0] v);
    return $signed({3'b000, v});
  endfunction

  function automatic logic signed [GW-1:0] ext2(input logic [DATA_W-1:0] v);
    return $signed({2'b00, v, 1'b0});
  endfunction

  function automatic logic [GW-1:0] abs_g(input logic signed [GW-1:0] v);
    logic [GW-1:0] u;
    u = v;
    return v[GW-1] ? (~u + GW'(1)) : u;
  endfunction

`ifdef SOBEL_MAG_OUT_EN
  function automatic logic [DATA_W-1:0] sat_mag(input logic [GW-1:0] s);
    if (|s[GW-1:DATA_W]) return '1;
    return s[DATA_W-1:0];
  endfunction
`endif

  state_t          state_q;
  logic [KW-1:0]   k_q;
  logic [RW-1:0]   cr_q;
  logic [CW-1:0]   cc_q;
  logic            trig;
  logic [DATA_W-1:0] pix;

  logic [DATA_W-1:0] lb1_q [IMG_W];
  logic [DATA_W-1:0] lb2_q [IMG_W];

  logic [DATA_W-1:0] win_p0 [3][3];
  logic [RW-1:0]     row_p0, row_p1, row_q;
  logic [CW-1:0]     col_p0, col_p1, col_q;
  logic              end_p0, end_p1;
  logic [DATA_W-1:0] thr_p0, thr_p1;
  logic              vld_p0, vld_p1;

  logic [DATA_W-1:0]     m [3][3];
  logic [2:0]            ok_r, ok_c;
  logic signed [GW-1:0]  gx_d, gy_d, gx_p1, gy_p1;
  logic [GW-1:0]         sum_d;
  logic                  dop_d;
  logic                  ready_q, end_q, dop_q;

  // Every enabled cycle past FILL produces a window centre.
  assign trig = Enable && (state_q != S_FILL);
  assign pix  = (state_q == S_FLUSH) ? '0 : DataIn;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_FILL;
      k_q     <= '0;
      cr_q    <= '0;
      cc_q    <= '0;
    end else if (Enable) begin
      case (state_q)
        S_FILL: begin
          k_q <= k_q + KW'(1);
          if (k_q == K_FILL_END) state_q <= S_RUN;
        end
        S_RUN: begin
          k_q <= k_q + KW'(1);
          if (k_q == K_RUN_END) state_q <= S_FLUSH;
        end
        S_FLUSH: begin
          if (k_q == K_FLUSH_END) begin
            k_q     <= '0;
            state_q <= S_FILL;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        default: state_q <= S_FILL;
      endcase
      if (trig) begin
        if (cc_q == COL_LAST) begin
          cc_q <= '0;
          cr_q <= (cr_q == ROW_LAST) ? '0 : cr_q + RW'(1);
        end else begin
          cc_q <= cc_q + CW'(1);
        end
      end
    end
  end

  // Stage p0: line buffers and window shift; newest column is {k-2W, k-W, k}.
  always_ff @(posedge Clk) begin
    if (Enable) begin
      lb1_q[0] <= pix;
      lb2_q[0] <= lb1_q[IMG_W-1];
      for (int i = 1; i < IMG_W; i++) begin
        lb1_q[i] <= lb1_q[i-1];
        lb2_q[i] <= lb2_q[i-1];
      end
      for (int r = 0; r < 3; r++) begin
        win_p0[r][0] <= win_p0[r][1];
        win_p0[r][1] <= win_p0[r][2];
      end
      win_p0[0][2] <= lb2_q[IMG_W-1];
      win_p0[1][2] <= lb1_q[IMG_W-1];
      win_p0[2][2] <= pix;
    end
    // Threshold travels with its result so a change of T between frames
    // does not leak into the previous frame's tail.
    if (trig) begin
      row_p0 <= cr_q;
      col_p0 <= cc_q;
      end_p0 <= (cr_q == ROW_LAST) && (cc_q == COL_LAST);
      thr_p0 <= T;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (Enable) begin
      vld_p0 <= trig;
      vld_p1 <= vld_p0;
    end
  end

  // Out-of-frame taps (including line-buffer wrap) are zeroed by position.
  always_comb begin
    ok_r = {row_p0 != ROW_LAST, 1'b1, row_p0 != '0};
    ok_c = {col_p0 != COL_LAST, 1'b1, col_p0 != '0};
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        m[r][c] = (ok_r[r] && ok_c[c]) ? win_p0[r][c] : '0;
    gx_d = ext1(m[0][2]) + ext2(m[1][2]) + ext1(m[2][2])
         - ext1(m[0][0]) - ext2(m[1][0]) - ext1(m[2][0]);
    gy_d = ext1(m[2][0]) + ext2(m[2][1]) + ext1(m[2][2])
         - ext1(m[0][0]) - ext2(m[0][1]) - ext1(m[0][2]);
  end

  // Stage p1: gradient register.
  always_ff @(posedge Clk) begin
    if (Enable) begin
      gx_p1  <= gx_d;
      gy_p1  <= gy_d;
      row_p1 <= row_p0;
      col_p1 <= col_p0;
      end_p1 <= end_p0;
      thr_p1 <= thr_p0;
    end
  end

  assign sum_d = abs_g(gx_p1) + abs_g(gy_p1);
  assign dop_d = sum_d > {3'b000, thr_p1};

  // Stage p2: magnitude / threshold register; values hold between results.
`ifdef SOBEL_MAG_OUT_EN
  logic [DATA_W-1:0] mag_q;
`endif
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ready_q <= 1'b0;
      end_q   <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      dop_q   <= 1'b0;
`ifdef SOBEL_MAG_OUT_EN
      mag_q   <= '0;
`endif
    end else begin
      ready_q <= Enable && vld_p1;
      end_q   <= Enable && vld_p1 && end_p1;
      if (Enable && vld_p1) begin
        row_q <= row_p1;
        col_q <= col_p1;
        dop_q <= dop_d;
`ifdef SOBEL_MAG_OUT_EN
        mag_q <= sat_mag(sum_d);
`endif
      end
    end
  end

`ifdef SOBEL_MAG_OUT_EN
  assign Mag = mag_q;
`else
  assign Mag = '0;
`endif
  assign Out_Row    = row_q;
  assign Out_Column = col_q;
  assign Dop        = dop_q;
  assign isReady    = ready_q;
  assign isEnd      = end_q;
  assign isPadding  = (state_q == S_FLUSH);

endmodule
